// File: rtl/ws_systolic_array.sv
// Weight-stationary systolic array computing Y = X*W.
// W (ROWS x COLS) is loaded row by row and held in the PEs. One ROWS-wide
// activation vector is accepted per beat and one COLS-wide result vector
// leaves L = ROWS+COLS-1 cycles later. Input skew and output deskew are
// internal, so callers see aligned vectors on both sides.
module ws_systolic_array #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W + $clog2(ROWS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    reuse_w,
  input  logic                    wgt_valid,
  output logic                    wgt_ready,
  input  logic [COLS*DATA_W-1:0]  wgt_in,
  input  logic                    act_valid,
  input  logic                    act_last,
  output logic                    act_ready,
  input  logic [ROWS*DATA_W-1:0]  act_in,
  output logic                    out_valid,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int L  = ROWS + COLS - 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic [L-1:0]    vld_q;
  logic            act_fire;

  logic signed [DATA_W-1:0] w_q      [ROWS][COLS];
  logic signed [DATA_W-1:0] a_q      [ROWS][COLS];
  logic signed [ACC_W-1:0]  p_q      [ROWS][COLS];
  logic signed [DATA_W-1:0] pe_act   [ROWS][COLS];
  logic signed [ACC_W-1:0]  pe_psum  [ROWS][COLS];
  logic signed [DATA_W-1:0] act_gated[ROWS];
  logic signed [DATA_W-1:0] skew_act [ROWS];

  // Full-precision multiply-accumulate; ACC_W is sized so this never wraps.
  function automatic logic signed [ACC_W-1:0] mac(
    input logic signed [ACC_W-1:0]  psum,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] w
  );
    logic signed [ACC_W-1:0] ax;
    logic signed [ACC_W-1:0] wx;
    ax = ACC_W'(a);
    wx = ACC_W'(w);
    return psum + ax * wx;
  endfunction

  assign wgt_ready = (state_q == LOAD_W);
  assign act_ready = (state_q == STREAM);
  assign busy      = (state_q != IDLE);
  assign act_fire  = act_valid && act_ready;
  assign out_valid = vld_q[L-1];
  // The last vector's result lands exactly when the drain counter expires.
  assign done      = (state_q == DRAIN) && (dcnt_q == CW'(L-1));

  // Control state, weight-row counter and drain counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rcnt_d  = '0;
          state_d = reuse_w ? STREAM : LOAD_W;
        end
      end
      LOAD_W: begin
        if (wgt_valid) begin
          if (rcnt_q == RW'(ROWS-1)) begin
            rcnt_d  = '0;
            state_d = STREAM;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
      end
      STREAM: begin
        if (act_valid && act_last) begin
          dcnt_d  = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dcnt_q == CW'(L-1)) state_d = IDLE;
        else                    dcnt_d  = dcnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Stationary weights: one row per accepted weight beat, kept across jobs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          w_q[i][j] <= '0;
    end else if (wgt_ready && wgt_valid) begin
      for (int j = 0; j < COLS; j++)
        w_q[rcnt_q][j] <= wgt_in[j*DATA_W +: DATA_W];
    end
  end

  // Bubbles and non-accepted cycles feed zeros so stale data never mixes in.
  always_comb begin
    for (int i = 0; i < ROWS; i++)
      act_gated[i] = act_fire ? act_in[i*DATA_W +: DATA_W] : '0;
  end

  // Input skew: row i sees its element i cycles late to meet the psum wave.
  for (genvar i = 0; i < ROWS; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign skew_act[i] = act_gated[i];
    end else begin : g_chain
      logic signed [DATA_W-1:0] chain_q [i];
      // Delay line of depth i for activation element i.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < i; k++) chain_q[k] <= '0;
        end else begin
          chain_q[0] <= act_gated[i];
          for (int k = 1; k < i; k++) chain_q[k] <= chain_q[k-1];
        end
      end
      assign skew_act[i] = chain_q[i-1];
    end
  end

  // PE inputs: activations flow right, partial sums flow down, row 0 starts at zero.
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      pe_act[i][0] = skew_act[i];
      for (int j = 1; j < COLS; j++) pe_act[i][j] = a_q[i][j-1];
    end
    for (int j = 0; j < COLS; j++) begin
      pe_psum[0][j] = '0;
      for (int i = 1; i < ROWS; i++) pe_psum[i][j] = p_q[i-1][j];
    end
  end

  // PE grid: pass activation right and accumulate the weighted product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j] <= '0;
          p_q[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_q[i][j] <= pe_act[i][j];
          p_q[i][j] <= mac(pe_psum[i][j], pe_act[i][j], w_q[i][j]);
        end
    end
  end

  // Output deskew: column j finishes COLS-1-j cycles before the last column.
  for (genvar j = 0; j < COLS; j++) begin : g_deskew
    localparam int D = COLS - 1 - j;
    if (D == 0) begin : g_direct
      assign out_data[j*ACC_W +: ACC_W] = p_q[ROWS-1][j];
    end else begin : g_chain
      logic signed [ACC_W-1:0] dly_q [D];
      // Delay line aligning column j with the last column.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= p_q[ROWS-1][j];
          for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign out_data[j*ACC_W +: ACC_W] = dly_q[D-1];
    end
  end

  // Valid bit travels the same L stages as the data it qualifies.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= (vld_q << 1) | L'(act_fire);
  end

endmodule

// File: tb/tb_ws_systolic_array.sv
// Bench for ws_systolic_array: fixed vector table, hand-written corner
// sequences and randomized jobs checked against a matrix-product model.
module tb_ws_systolic_array;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 2*DATA_W + $clog2(ROWS);
  localparam int L      = ROWS + COLS - 1;

  logic                   clk = 1'b0;
  logic                   rst_n, start, reuse_w, wgt_valid, wgt_ready;
  logic                   act_valid, act_last, act_ready, out_valid, busy, done;
  logic [COLS*DATA_W-1:0] wgt_in;
  logic [ROWS*DATA_W-1:0] act_in;
  logic [COLS*ACC_W-1:0]  out_data;

  ws_systolic_array #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_w(reuse_w),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_in(wgt_in),
    .act_valid(act_valid), .act_last(act_last), .act_ready(act_ready), .act_in(act_in),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [COLS*ACC_W-1:0] y;
    logic [31:0]           cyc;
    logic                  last;
  } exp_t;

  typedef struct packed {
    logic [1:0]             mode;
    logic [ROWS*DATA_W-1:0] x;
    logic [COLS*ACC_W-1:0]  y;
  } vec_t;

  exp_t sb[$];
  int   wm   [ROWS][COLS];
  int   wnew [ROWS][COLS];
  bit   mon_en  = 1'b0;
  bit   wr_seen = 1'b0;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic logic [ROWS*DATA_W-1:0] px(input int a0, input int a1, input int a2, input int a3);
    return {DATA_W'(a3), DATA_W'(a2), DATA_W'(a1), DATA_W'(a0)};
  endfunction

  function automatic logic [COLS*ACC_W-1:0] py(input int y0, input int y1, input int y2, input int y3);
    return {ACC_W'(y3), ACC_W'(y2), ACC_W'(y1), ACC_W'(y0)};
  endfunction

  // Reference: y[j] = sum_i x[i]*W[i][j] in plain integer arithmetic.
  function automatic logic [COLS*ACC_W-1:0] model_y(input logic [ROWS*DATA_W-1:0] x);
    logic [COLS*ACC_W-1:0] y;
    int s;
    y = '0;
    for (int j = 0; j < COLS; j++) begin
      s = 0;
      for (int i = 0; i < ROWS; i++)
        s += int'($signed(x[i*DATA_W +: DATA_W])) * wm[i][j];
      y[j*ACC_W +: ACC_W] = ACC_W'(s);
    end
    return y;
  endfunction

  function automatic logic [ROWS*DATA_W-1:0] rand_x();
    logic [ROWS*DATA_W-1:0] x;
    for (int i = 0; i < ROWS; i++) x[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return x;
  endfunction

  function automatic int rand_w();
    case ($urandom_range(0, 5))
      0:       return -128;
      1:       return 127;
      default: return int'($signed(DATA_W'($urandom)));
    endcase
  endfunction

  // Output monitor: every cycle out_valid/done must match the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (wgt_ready) wr_seen = 1'b1;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        chk("out_valid_beat", out_valid, 1'b1);
        chk("out_data", out_data, sb[0].y);
        chk("done_on_beat", done, sb[0].last);
        void'(sb.pop_front());
      end else begin
        chk("out_valid_quiet", out_valid, 1'b0);
        chk("done_quiet", done, 1'b0);
      end
    end
  end

  task automatic do_start(input bit reuse);
    start = 1'b1; reuse_w = reuse;
    @(negedge clk);
    start = 1'b0; reuse_w = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("wgt_ready_after_start", wgt_ready, !reuse);
    chk("act_ready_after_start", act_ready, reuse);
  endtask

  task automatic load_w(input bit gaps);
    do_start(1'b0);
    for (int r = 0; r < ROWS; r++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wgt_valid = 1'b0;
        @(negedge clk);
      end
      for (int j = 0; j < COLS; j++) wgt_in[j*DATA_W +: DATA_W] = DATA_W'(wnew[r][j]);
      wgt_valid = 1'b1;
      @(negedge clk);
    end
    wgt_valid = 1'b0;
    wgt_in    = $urandom;
    wm        = wnew;
    chk("act_ready_after_load", act_ready, 1'b1);
    chk("wgt_ready_after_load", wgt_ready, 1'b0);
  endtask

  task automatic send_act(input logic [ROWS*DATA_W-1:0] x, input bit last,
                          input logic [COLS*ACC_W-1:0] yexp);
    int   g;
    exp_t e;
    g = 0;
    act_in = x; act_valid = 1'b1; act_last = last;
    while (!act_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("act_ready_for_beat", act_ready, 1'b1);
    if (act_ready) begin
      e.y = yexp; e.cyc = cyc + L; e.last = last;
      sb.push_back(e);
    end
    @(negedge clk);
    act_valid = 1'b0; act_last = 1'b0; act_in = $urandom;
  endtask

  task automatic wait_idle();
    bit pd;
    int g;
    g = 0;
    while ((busy || sb.size() != 0) && g < 64) begin
      pd = done;
      @(negedge clk);
      g++;
      if (pd) chk("busy_after_done", busy, 1'b0);
    end
    chk("job_drained", {busy, sb.size() != 0}, 2'b00);
  endtask

  task automatic set_mode(input int m);
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++)
        case (m)
          0:       wnew[i][j] = (i == j) ? 1 : 0;
          1:       wnew[i][j] = -128;
          2:       wnew[i][j] = 127;
          default: wnew[i][j] = 1;
        endcase
  endtask

  task automatic rand_weights();
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) wnew[i][j] = rand_w();
  endtask

  task automatic rand_job(input bit reuse, input int n, input int gap_pct);
    logic [ROWS*DATA_W-1:0] x;
    if (reuse) do_start(1'b1);
    else begin
      rand_weights();
      load_w(1'b1);
    end
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        // bubble cycle, with stray start/weight beats that must be ignored
        start = 1'b1; wgt_valid = 1'b1; wgt_in = $urandom;
        @(negedge clk);
        start = 1'b0; wgt_valid = 1'b0;
      end
      x = rand_x();
      send_act(x, k == n-1, model_y(x));
    end
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ROWS*DATA_W-1:0] x0, x1;
    logic [COLS*ACC_W-1:0]  y2;
    int prev_mode;

    tbl[0] = '{mode: 2'd0, x: px(1, 2, 3, 4),        y: py(1, 2, 3, 4)};
    tbl[1] = '{mode: 2'd0, x: px(-5, 7, 0, -128),    y: py(-5, 7, 0, -128)};
    tbl[2] = '{mode: 2'd1, x: px(-128, -128, -128, -128), y: py(65536, 65536, 65536, 65536)};
    tbl[3] = '{mode: 2'd2, x: px(-128, -128, -128, -128), y: py(-65024, -65024, -65024, -65024)};
    tbl[4] = '{mode: 2'd3, x: px(1, 2, 3, 4),        y: py(10, 10, 10, 10)};

    start = 0; reuse_w = 0; wgt_valid = 0; wgt_in = '0;
    act_valid = 0; act_last = 0; act_in = '0; rst_n = 0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) wm[i][j] = 0;
    repeat (2) @(negedge clk);

    chk("rst_wgt_ready", wgt_ready, 1'b0);
    chk("rst_act_ready", act_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_data", out_data, '0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // activations offered while idle must be dropped
    act_valid = 1'b1; act_in = $urandom;
    repeat (3) @(negedge clk);
    act_valid = 1'b0;
    chk("idle_ignores_act", busy, 1'b0);

    // table vectors: reload weights only when the mode changes
    prev_mode = -1;
    for (int t = 0; t < 5; t++) begin
      if (int'(tbl[t].mode) != prev_mode) begin
        set_mode(int'(tbl[t].mode));
        load_w(1'b0);
      end else begin
        do_start(1'b1);
      end
      send_act(tbl[t].x, 1'b1, tbl[t].y);
      wait_idle();
      prev_mode = int'(tbl[t].mode);
    end

    // bubble: x0, one idle cycle, x1 (last)
    rand_weights();
    load_w(1'b0);
    x0 = rand_x();
    x1 = rand_x();
    send_act(x0, 1'b0, model_y(x0));
    @(negedge clk);
    send_act(x1, 1'b1, model_y(x1));
    wait_idle();

    // weight reuse: result is twice weight row 0
    wr_seen = 1'b0;
    do_start(1'b1);
    for (int j = 0; j < COLS; j++) y2[j*ACC_W +: ACC_W] = ACC_W'(2 * wm[0][j]);
    send_act(px(2, 0, 0, 0), 1'b1, y2);
    wait_idle();
    chk("wgt_ready_during_reuse", wr_seen, 1'b0);

    // back-to-back: 8 vectors without gaps
    rand_weights();
    load_w(1'b0);
    for (int k = 0; k < 8; k++) begin
      x0 = rand_x();
      send_act(x0, k == 7, model_y(x0));
    end
    wait_idle();

    // randomized jobs with bubbles and mixed weight reuse
    for (int n = 0; n < 8; n++)
      rand_job($urandom_range(0, 2) == 0, $urandom_range(1, 10), 30);

    // reset mid-stream after three accepted vectors
    rand_weights();
    load_w(1'b0);
    for (int k = 0; k < 3; k++) begin
      x0 = rand_x();
      send_act(x0, 1'b0, model_y(x0));
    end
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_act_ready", act_ready, 1'b0);
    chk("midrst_out_data", out_data, '0);
    rst_n = 1'b1;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < COLS; j++) wm[i][j] = 0;
    repeat (L + 3) @(negedge clk);

    // weights were cleared by reset, so a reuse job yields zeros
    do_start(1'b1);
    x0 = rand_x();
    x0[7:0] = 8'h80;
    send_act(x0, 1'b1, '0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ws_systolic_array.md
# ws_systolic_array

Parametrised weight-stationary systolic array, the successor to the fixed 10x10 array. It computes Y = X·W. W (ROWS x COLS, signed) is loaded once and held in the PEs. X is streamed one ROWS-wide vector per beat, and each result vector is COLS-wide. The block adds a valid/ready handshake, internal input skew and output deskew, bubble tolerance, arbitrary-length jobs, and weight reuse across jobs. It sits between the NPU's activation buffer and its output/accumulation stage.

## Interface
- ROWS, 4: PE rows (dot-product length).
- COLS, 4: PE columns (outputs per vector).
- DATA_W, 8: signed width of activations and weights.
- ACC_W, 2*DATA_W+$clog2(ROWS): signed accumulator/output width.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  begin a job, sampled only in IDLE.
- reuse_w  in  1  sampled with start: 1 skips LOAD_W and keeps the held weights.
- wgt_valid  in  1  weight row beat valid.
- wgt_ready  out  1  high only in LOAD_W.
- wgt_in  in  COLS*DATA_W  weight row r; element j at [j*DATA_W +: DATA_W].
- act_valid  in  1  activation vector valid.
- act_last  in  1  marks the final vector of the job.
- act_ready  out  1  high only in STREAM.
- act_in  in  ROWS*DATA_W  vector x_m; element i at [i*DATA_W +: DATA_W].
- out_valid  out  1  out_data holds y_m.
- out_data  out  COLS*ACC_W  y_m[j] = sum_i x_m[i]*W[i][j], column j at [j*ACC_W +: ACC_W].
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at job completion.

## Operation
- FSM states: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE:
  - start && !reuse_w goes to LOAD_W.
  - start && reuse_w goes to STREAM.
- LOAD_W: each wgt_valid&&wgt_ready beat writes row r = 0..ROWS-1 in order. After beat ROWS-1, go to STREAM.
- STREAM: each act_valid&&act_ready beat is accepted. When the accepted beat has act_last=1, go to DRAIN.
- DRAIN: a counter runs L = ROWS+COLS-1 cycles from the last acceptance. done pulses in the same cycle as the final out_valid, then the FSM returns to IDLE.
- PE(i,j): registers act to the right. psum_out <= psum_in + act*w, full ACC_W signed precision, with no truncation or saturation. Row 0 has psum_in = 0.
- Input skew: element i of act_in is delayed i cycles. Output deskew: column j is delayed COLS-1-j cycles.
- Bubbles (act_valid=0 in STREAM) inject zero activations. A valid bit travels through an L-deep shift register alongside the data.
- Weights persist after done and are cleared only by reset.
- Input qualification:
  - start outside IDLE is ignored.
  - wgt_valid outside LOAD_W is ignored.
  - act_valid outside STREAM is ignored.
- There is no output backpressure; the consumer must accept every out_valid beat.

## Timing
- Reset (rst_n=0 at an edge) clears all of the following:
  - state = IDLE;
  - wgt_ready, act_ready, out_valid, busy, done = 0;
  - out_data = 0;
  - all weights, PE registers and the valid pipeline = 0.
- Reset mid-job aborts the job. No out_valid or done is produced for in-flight vectors.
- Latency: a vector accepted at edge t gives out_valid=1 with its y_m in the cycle after edge t+L-1, i.e. L cycles later.
- Throughput: 1 vector/cycle. Out-of-order results never occur, and gaps on input are reproduced on output.
- wgt_ready rises the cycle after the start edge. act_ready rises the cycle after the last weight beat, or the cycle after start when reuse_w=1.
- An act_last vector accepted at t gives done=1 coincident with out_valid for that vector, and busy=0 one cycle later.
- A new start is accepted on the edge where busy=0.

## Test plan
- ROWS=COLS=4, DATA_W=8: load W=identity, stream x=[1,2,3,4] with act_last -> out_valid 7 cycles after acceptance, out_data=[1,2,3,4], done same cycle.
- Extreme values:
  - Stimulus: all weights = -128, x = [-128,-128,-128,-128].
  - Required response: every column = 65536, fits ACC_W=18 with no wrap.
  - Also: all weights = 127, x = -128 -> every column = -65024.
- Bubbles: accept x0, one idle cycle, accept x1 (last) -> out_valid pattern 1,0,1 with correct y0 and y1, done on the y1 beat.
- Weight reuse: after the job above, start with reuse_w=1 and x=[2,0,0,0] -> wgt_ready never asserts, result equals 2*W row 0.
- Back-to-back: 8 consecutive vectors with no gaps, last on the 8th -> 8 consecutive out_valid beats matching a reference model, done on the 8th.
- Reset mid-STREAM:
  - Stimulus: drive rst_n=0 for one edge after 3 vectors are accepted.
  - Required response: next cycle out_valid=0, busy=0, and no late outputs appear.
  - Follow-up: a reuse_w job then yields all-zero results.
